// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer: shares the byte-wide RAM between fetch and data ports,
// serialising word/half/byte requests into big-endian byte cycles.
// Optional misalignment trap: define MEM_PORT_ALIGN_CHECK_EN.

module mem_port_sequencer #(
  parameter int ADDR_W        = 9,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_signed,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic              gnt_dm;
  logic              gnt_if;
  logic              gnt_any;
  logic [1:0]        dm_last;
  logic              mis;

  logic              sel_dm_q;
  logic              we_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [1:0]        last_q;
  logic [1:0]        k_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       sh_q;
  logic              err_q;

  logic [31:0]       sh_nx;
  logic [31:0]       ext;
  logic [1:0]        widx;
  logic [7:0]        wbyte;
  logic              xfer_end;

  // Pick the winner when both ports request in the same IDLE cycle
  always_comb begin
    gnt_dm = 1'b0;
    gnt_if = 1'b0;
    if (dm_req && if_req) begin
      gnt_dm = DATA_PRIORITY;
      gnt_if = !DATA_PRIORITY;
    end else begin
      gnt_dm = dm_req;
      gnt_if = if_req;
    end
  end

  assign gnt_any = gnt_dm | gnt_if;

  // Index of the last byte for a data request (N-1)
  always_comb begin
    dm_last = 2'd3;
    unique case (dm_size)
      2'b00:   dm_last = 2'd0;
      2'b01:   dm_last = 2'd1;
      default: dm_last = 2'd3;
    endcase
  end

`ifdef MEM_PORT_ALIGN_CHECK_EN
  // Misaligned requests are granted but bypass the RAM entirely
  always_comb begin
    mis = 1'b0;
    if (gnt_dm) begin
      unique case (dm_size)
        2'b00:   mis = 1'b0;
        2'b01:   mis = dm_addr[0];
        default: mis = (dm_addr[1:0] != 2'b00);
      endcase
    end else if (gnt_if) begin
      mis = (if_addr[1:0] != 2'b00);
    end
  end
`else
  assign mis = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign xfer_end = (k_q == last_q);

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_any) state_nx = mis ? DONE : XFER;
      end
      XFER: begin
        if (xfer_end) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read bytes arrive MSB first, so each new byte shifts in at the bottom
  assign sh_nx = {sh_q[23:0], ram_rdata};

  // Extend the assembled load to 32 bits
  always_comb begin
    ext = sh_nx;
    unique case (size_q)
      2'b00: ext = {{24{sgn_q & sh_nx[7]}}, sh_nx[7:0]};
      2'b01: ext = {{16{sgn_q & sh_nx[15]}}, sh_nx[15:0]};
      default: ext = sh_nx;
    endcase
  end

  // Store byte for cycle k is byte (N-1-k) of the latched data
  assign widx = last_q - k_q;

  always_comb begin
    wbyte = 8'h00;
    unique case (widx)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Latch the granted request, step the byte counter, capture results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_dm_q <= 1'b0;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      size_q   <= 2'b00;
      last_q   <= 2'd0;
      k_q      <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      sh_q     <= 32'h0;
      err_q    <= 1'b0;
      if_rdata <= 32'h0;
      dm_rdata <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            sel_dm_q <= gnt_dm;
            we_q     <= gnt_dm & dm_we;
            sgn_q    <= gnt_dm & dm_signed;
            size_q   <= gnt_dm ? dm_size : 2'b10;
            last_q   <= gnt_dm ? dm_last : 2'd3;
            addr_q   <= gnt_dm ? dm_addr[ADDR_W-1:0]
                               : if_addr[ADDR_W-1:0];
            wdata_q  <= dm_wdata;
            k_q      <= 2'd0;
            sh_q     <= 32'h0;
            err_q    <= mis;
          end
        end
        XFER: begin
          k_q  <= k_q + 2'd1;
          sh_q <= sh_nx;
          if (xfer_end && !we_q) begin
            if (sel_dm_q) dm_rdata <= ext;
            else          if_rdata <= sh_nx;
          end
        end
        DONE: begin
          k_q <= 2'd0;
        end
        default: begin
          k_q <= 2'd0;
        end
      endcase
    end
  end

  // RAM strobes are decoded from state so reset drops them at once
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (state == XFER) begin
      ram_addr = addr_q + {{(ADDR_W-2){1'b0}}, k_q};
      ram_we   = we_q;
      if (we_q) ram_wdata = wbyte;
    end
  end

  assign busy    = (state != IDLE);
  assign if_done = (state == DONE) && !sel_dm_q;
  assign dm_done = (state == DONE) && sel_dm_q;

`ifdef MEM_PORT_ALIGN_CHECK_EN
  assign dm_err = dm_done && err_q;

  logic unused_hi;
  assign unused_hi = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};
`else
  assign dm_err = 1'b0;

  logic unused_hi;
  assign unused_hi = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W], err_q};
`endif

endmodule
